grad_frame_sequencer: RTL and testbench
=======================================

Name: grad_frame_sequencer

Overview:
- Upstream feeder for the OCRA1 GPA SPI serialiser.
- Buffers 32-bit gradient words (bits 26:25 channel, bit 24 broadcast, bits 23:0 DAC payload) from the gradient memory side in a small FIFO.
- On each programmable update tick, pops one "frame" and issues it to the serialiser one word per cycle. A frame is zero or more load words followed by one broadcast word.
- Holds the broadcast word until the serialiser is idle, so no update is lost.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 words (16).
- INTERVAL_W, 16, width of the tick interval register.

Ports:
- clk  in  1  system clock (122.88 MHz)
- rst_n  in  1  reset, synchronous, active-low
- wr_data_i  in  32  gradient word to buffer
- wr_valid_i  in  1  write strobe, one word per cycle
- wr_ready_o  out  1  FIFO not full
- start_i  in  1  one-cycle pulse: begin ticking
- stop_i  in  1  one-cycle pulse: stop after current frame
- interval_i  in  INTERVAL_W  tick period minus 1, in clk cycles
- out_data_o  out  32  word to serialiser data_i
- out_valid_o  out  1  one-cycle strobe to serialiser valid_i
- out_busy_i  in  1  serialiser busy_o
- running_o  out  1  high in any state except IDLE
- fifo_count_o  out  DEPTH_LOG2+1  words currently buffered
- underrun_o  out  1  sticky: FIFO empty mid-frame
- overflow_o  out  1  sticky: write attempted while full
- late_o  out  1  sticky: tick arrived while a frame was still in progress

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO emptied; state IDLE; tick counter 0; guard counter 0. All outputs 0 except wr_ready_o=1.
- FIFO:
  - wr_ready_o = (count < DEPTH).
  - Write occurs when wr_valid_i && wr_ready_o.
  - wr_valid_i while full: word dropped, overflow_o set.
  - Simultaneous write and pop: legal at any count, including full; count unchanged.
  - Pointers wrap modulo DEPTH.
  - fifo_count_o is registered and reflects the count after the cycle's operations.
- Tick generator:
  - Active only when running. Counter is cleared on start_i.
  - A tick fires in the cycle after start_i, then every interval_i+1 cycles.
  - interval_i=0 means a tick every cycle. interval_i is sampled at each tick reload.
- States:
  - IDLE:
    - start_i: clear underrun_o, overflow_o and late_o; go to WAIT_TICK.
    - stop_i: ignored.
  - WAIT_TICK:
    - stop_i: go to IDLE; this wins over a same-cycle tick.
    - tick: go to ISSUE.
  - ISSUE:
    - FIFO empty: set underrun_o; abandon the frame; go to WAIT_TICK, or IDLE if stop is pending.
    - Head word with bit24=0: pop it, drive out_data_o=word and out_valid_o=1 next cycle; remain in ISSUE.
    - Head word with bit24=1: go to WAIT_BUSY without popping.
  - WAIT_BUSY:
    - Issue the broadcast word when out_busy_i==0 && guard==0: pop, strobe, load guard=3, go to WAIT_TICK (or IDLE if stop is pending).
    - Guard covers the serialiser's 2-cycle input pipeline plus 1 cycle before its busy_o rises.
    - Guard decrements every cycle when nonzero, in all states.
- Stop during ISSUE or WAIT_BUSY: latched as stop-pending; the frame completes first.
- Tick during ISSUE or WAIT_BUSY: dropped, late_o set.
- Outputs:
  - out_valid_o is a registered single-cycle pulse, never high 2 cycles for the same word.
  - out_data_o holds its last value otherwise.
- Latency: tick in cycle T -> first out_valid_o in cycle T+2 (state change at T+1, registered output at T+2).
- rst_n low mid-frame: frame discarded, no further strobes, FIFO emptied.

Test Plan:
- Reset, then push 0x0000_1234 (ch0), 0x0200_5678 (ch1), 0x0700_9ABC (ch3 broadcast); start_i with interval_i=99, out_busy_i=0 -> three strobes on consecutive cycles starting 2 cycles after the tick, data in order; fifo_count_o 3->0; running_o=1.
- Same frame with out_busy_i=1 held 50 cycles after the tick -> two load strobes issue immediately; broadcast strobe appears exactly 1 cycle after out_busy_i falls.
- Push 17 words into the 16-deep FIFO with no pop -> wr_ready_o=0 after the 16th; overflow_o=1; fifo_count_o=16.
- Push only 0x0000_0001 (no broadcast), then start -> one strobe, underrun_o=1, state back to WAIT_TICK; the next tick produces no strobe.
- interval_i=3 with frames whose broadcast is held by out_busy_i for 10 cycles -> late_o=1; no strobe occurs inside the 3-cycle guard after each broadcast.
- stop_i asserted while in WAIT_BUSY -> broadcast still issued, then running_o=0. A later start_i clears all sticky flags.

Source files
------------

// File: rtl/grad_frame_sequencer.sv
// Buffers gradient words and releases one frame per update tick to the OCRA1 GPA
// SPI serialiser. A frame is zero or more load words followed by a broadcast word.
module grad_frame_sequencer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  output logic [31:0]           out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_busy_i,
  output logic                  running_o,
  output logic [DEPTH_LOG2:0]   fifo_count_o,
  output logic                  underrun_o,
  output logic                  overflow_o,
  output logic                  late_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TICK, S_ISSUE, S_WAIT_BUSY} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [INTERVAL_W-1:0] r_tick_cnt;
  logic [1:0]            r_guard;
  logic                  r_stop_pend;
  logic                  r_underrun;
  logic                  r_overflow;
  logic                  r_late;
  logic                  r_out_valid;
  logic [31:0]           r_out_data;

  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  logic        w_running;
  logic        w_tick;
  logic        w_stop_eff;
  logic        w_bcast_ok;
  logic        w_wr_en;
  logic        w_pop;
  logic        w_bcast;
  logic        w_set_underrun;
  logic        w_clear_flags;
  logic        w_frame_busy;

  // Count never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign w_full       = r_count[DEPTH_LOG2];
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_running    = (r_state != S_IDLE);
  assign w_tick       = w_running && (r_tick_cnt == '0);
  assign w_stop_eff   = r_stop_pend || stop_i;
  assign w_bcast_ok   = !out_busy_i && (r_guard == 2'd0);
  assign w_frame_busy = (r_state == S_ISSUE) || (r_state == S_WAIT_BUSY);
  assign w_wr_en      = wr_valid_i && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start_i) w_next = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (stop_i)      w_next = S_IDLE;
        else if (w_tick) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_empty)         w_next = w_stop_eff ? S_IDLE : S_WAIT_TICK;
        else if (w_head[24]) w_next = w_bcast_ok ? (w_stop_eff ? S_IDLE : S_WAIT_TICK)
                                                 : S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (w_bcast_ok) w_next = w_stop_eff ? S_IDLE : S_WAIT_TICK;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop          = 1'b0;
    w_bcast        = 1'b0;
    w_set_underrun = 1'b0;
    w_clear_flags  = 1'b0;
    case (r_state)
      S_IDLE: w_clear_flags = start_i;
      S_ISSUE: begin
        if (w_empty) begin
          w_set_underrun = 1'b1;
        end else if (!w_head[24]) begin
          w_pop = 1'b1;
        end else if (w_bcast_ok) begin
          w_pop   = 1'b1;
          w_bcast = 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        w_pop   = w_bcast_ok;
        w_bcast = w_bcast_ok;
      end
      default: ;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= wr_data_i;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tick_cnt  <= '0;
      r_guard     <= 2'd0;
      r_stop_pend <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
      r_late      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (start_i && r_state == S_IDLE) r_tick_cnt <= '0;
      else if (w_tick)                  r_tick_cnt <= interval_i;
      else if (r_tick_cnt != '0)        r_tick_cnt <= r_tick_cnt - 1'b1;

      // Guard spans the serialiser's input pipeline until its busy flag rises.
      if (w_bcast)               r_guard <= 2'd3;
      else if (r_guard != 2'd0)  r_guard <= r_guard - 1'b1;

      r_stop_pend <= (w_next == S_ISSUE || w_next == S_WAIT_BUSY) &&
                     (r_stop_pend || (stop_i && w_frame_busy));

      if (w_clear_flags) begin
        r_underrun <= 1'b0;
        r_overflow <= 1'b0;
        r_late     <= 1'b0;
      end else begin
        if (w_set_underrun)            r_underrun <= 1'b1;
        if (wr_valid_i && !w_wr_en)    r_overflow <= 1'b1;
        if (w_tick && w_frame_busy)    r_late     <= 1'b1;
      end

      r_out_valid <= w_pop;
      if (w_pop) r_out_data <= w_head;
    end
  end

  assign wr_ready_o   = !w_full;
  assign out_data_o   = r_out_data;
  assign out_valid_o  = r_out_valid;
  assign running_o    = w_running;
  assign fifo_count_o = r_count;
  assign underrun_o   = r_underrun;
  assign overflow_o   = r_overflow;
  assign late_o       = r_late;

endmodule

// File: tb/tb_grad_frame_sequencer.sv
// Directed bench for grad_frame_sequencer: frame issue, busy hold, overflow,
// underrun, late ticks with broadcast guard, stop handling and mid-frame reset.
module tb_grad_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        start;
  logic        stop;
  logic [15:0] interval;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_busy;
  logic        running;
  logic [4:0]  fifo_count;
  logic        underrun;
  logic        overflow;
  logic        late;

  int n_checks = 0;
  int n_errors = 0;
  int strobes;

  grad_frame_sequencer #(.DEPTH_LOG2(4), .INTERVAL_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data_i    (wr_data),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .start_i      (start),
    .stop_i       (stop),
    .interval_i   (interval),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_busy_i   (out_busy),
    .running_o    (running),
    .fifo_count_o (fifo_count),
    .underrun_o   (underrun),
    .overflow_o   (overflow),
    .late_o       (late)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    wr_data  = w;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic count_strobes(input int n);
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (out_valid) strobes++;
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_data = '0; wr_valid = 1'b0; start = 1'b0; stop = 1'b0;
    interval = 16'd99; out_busy = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    check("rst_ready", wr_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_running", running, 0);
    check("rst_flags", {underrun, overflow, late}, 0);
    check("rst_data", out_data, 0);

    // Frame of two loads and a broadcast, serialiser idle
    push(32'h0000_1234); push(32'h0200_5678); push(32'h0700_9ABC);
    check("t1_count3", fifo_count, 3);
    start = 1'b1; step(); start = 1'b0;
    check("t1_running", running, 1);
    step();
    check("t1_no_strobe_t1", out_valid, 0);
    step();
    check("t1_s0_valid", out_valid, 1);
    check("t1_s0_data", out_data, 32'h0000_1234);
    check("t1_count2", fifo_count, 2);
    step();
    check("t1_s1_valid", out_valid, 1);
    check("t1_s1_data", out_data, 32'h0200_5678);
    step();
    check("t1_s2_valid", out_valid, 1);
    check("t1_s2_data", out_data, 32'h0700_9ABC);
    check("t1_count0", fifo_count, 0);
    step();
    check("t1_single_pulse", out_valid, 0);
    check("t1_running_after", running, 1);

    // Same frame with the serialiser busy: broadcast held until busy falls
    stop = 1'b1; step(); stop = 1'b0;
    check("t2_stopped", running, 0);
    push(32'h0000_1234); push(32'h0200_5678); push(32'h0700_9ABC);
    out_busy = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step();
    step();
    check("t2_s0_data", out_data, 32'h0000_1234);
    check("t2_s0_valid", out_valid, 1);
    step();
    check("t2_s1_data", out_data, 32'h0200_5678);
    step();
    check("t2_held_valid", out_valid, 0);
    check("t2_held_count", fifo_count, 1);
    count_strobes(45);
    check("t2_no_strobe_busy", strobes, 0);
    out_busy = 1'b0;
    step();
    check("t2_bcast_valid", out_valid, 1);
    check("t2_bcast_data", out_data, 32'h0700_9ABC);
    check("t2_count0", fifo_count, 0);

    // Overflow: 17 writes into 16 entries while idle
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 16; i++) push(32'h0000_0100 + i);
    check("t3_full_ready", wr_ready, 0);
    check("t3_full_count", fifo_count, 16);
    check("t3_no_ovf_yet", overflow, 0);
    push(32'h0000_0DEA);
    check("t3_overflow", overflow, 1);
    check("t3_count16", fifo_count, 16);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("t3_rst_count", fifo_count, 0);
    check("t3_rst_ready", wr_ready, 1);
    check("t3_rst_ovf", overflow, 0);

    // Frame without a broadcast word: underrun
    push(32'h0000_0001);
    interval = 16'd3;
    start = 1'b1; step(); start = 1'b0;
    step();
    step();
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 32'h0000_0001);
    check("t4_no_underrun_yet", underrun, 0);
    step();
    check("t4_underrun", underrun, 1);
    check("t4_still_running", running, 1);
    check("t4_pulse_end", out_valid, 0);
    count_strobes(6);
    check("t4_next_tick_silent", strobes, 0);
    check("t4_no_late", late, 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("t4_stopped", running, 0);

    // Broadcast-only frames held by busy: late ticks and guard spacing, then stop in WAIT_BUSY
    push(32'h0100_00AA); push(32'h0300_00BB); push(32'h0500_00CC);
    out_busy = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    check("t5_underrun_cleared", underrun, 0);
    step(); step(); step(); step();
    check("t5_not_late_yet", late, 0);
    step();
    check("t5_late", late, 1);
    step(); step(); step(); step(); step();
    out_busy = 1'b0;
    step();
    check("t5_b0_valid", out_valid, 1);
    check("t5_b0_data", out_data, 32'h0100_00AA);
    count_strobes(3);
    check("t5_guard0_quiet", strobes, 0);
    step();
    check("t5_b1_valid", out_valid, 1);
    check("t5_b1_data", out_data, 32'h0300_00BB);
    count_strobes(2);
    check("t5_guard1_quiet", strobes, 0);
    out_busy = 1'b1;
    step();
    check("t5_hold_valid", out_valid, 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("t5_stop_pending_running", running, 1);
    check("t5_stop_pending_valid", out_valid, 0);
    step();
    out_busy = 1'b0;
    step();
    check("t5_b2_valid", out_valid, 1);
    check("t5_b2_data", out_data, 32'h0500_00CC);
    check("t5_stopped", running, 0);
    check("t5_count0", fifo_count, 0);
    count_strobes(6);
    check("t5_idle_quiet", strobes, 0);

    // Set overflow as well, then a new start clears every sticky flag
    for (int i = 0; i < 17; i++) push(32'h0000_0010 + i);
    check("t6_overflow", overflow, 1);
    check("t6_late_still", late, 1);
    start = 1'b1; step(); start = 1'b0;
    check("t6_flags_cleared", {underrun, overflow, late}, 0);
    check("t6_running", running, 1);
    step();
    step();
    check("t6_s0_data", out_data, 32'h0000_0010);
    check("t6_count15", fifo_count, 15);

    // Reset mid-frame discards everything
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("t7_valid", out_valid, 0);
    check("t7_running", running, 0);
    check("t7_count", fifo_count, 0);
    count_strobes(5);
    check("t7_quiet", strobes, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
